// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: N-to-1 operand selector feeding the ALU operand stage.
// The selected {data, sel, err} is captured on accept into a two-entry
// skid buffer (main + skid) so the block streams one item per cycle while
// keeping in_ready a registered signal.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the posedge (in_valid & in_ready = accept, out_valid & out_ready =
// deliver). Once out_valid is high the out_* values stay frozen until the
// item is delivered; an upstream holding in_valid while in_ready is low is
// simply ignored until in_ready returns.
module operand_sel_pipe #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 16,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ERR_W-1:0]      err_cnt
);

    // Buffer occupancy; EMPTY / ONE (main valid) / FULL (main + skid valid)
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             deliver;
    logic             load_main_new;
    logic             load_main_skid;
    logic             load_skid;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    logic [WIDTH-1:0] main_data, skid_data;
    logic [SEL_W-1:0] main_sel,  skid_sel;
    logic             main_err,  skid_err;

    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign out_valid = (state != S_EMPTY);
    assign out_data  = main_data;
    assign out_sel   = main_sel;
    assign out_err   = main_err;

    // Operand mux: out-of-range selects match no input and yield zero data
    always_comb begin
        sel_data = '0;
        sel_err  = (32'(in_sel) >= N_IN);
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and which register loads what
    always_comb begin
        state_nxt      = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt     = S_ONE;
                    load_main_new = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && deliver) begin
                    load_main_new = 1'b1;
                end else if (accept) begin
                    state_nxt = S_FULL;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only draining is possible
                if (deliver) begin
                    state_nxt      = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // in_ready looks ahead at the next occupancy so it is low exactly while FULL
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt != S_FULL);
        end
    end

    // Main register: drives out_*, loads a fresh item or the skid contents
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            main_sel  <= '0;
            main_err  <= 1'b0;
        end else if (load_main_new) begin
            main_data <= sel_data;
            main_sel  <= in_sel;
            main_err  <= sel_err;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            main_err  <= skid_err;
        end
    end

    // Skid register: catches the item accepted while main is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else if (load_skid) begin
            skid_data <= sel_data;
            skid_sel  <= in_sel;
            skid_err  <= sel_err;
        end
    end

    // Saturating count of accepted out-of-range requests
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && sel_err && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: instance a (N_IN=16, ERR_W=8) and
// instance b (N_IN=12, ERR_W=2, downstream always ready).
module tb_operand_sel_pipe;

    localparam int PW = 21;  // packed {data[15:0], sel[3:0], err}

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [255:0] vec;
    logic [3:0]   in_sel;

    logic         a_iv, a_ir, a_oe, a_ov, a_or;
    logic [15:0]  a_od;
    logic [3:0]   a_os;
    logic [7:0]   a_ec;

    logic         b_iv, b_ir, b_oe, b_ov;
    logic         b_or = 1'b1;
    logic [15:0]  b_od;
    logic [3:0]   b_os;
    logic [1:0]   b_ec;
    logic [191:0] b_data;
    assign b_data = vec[191:0];

    operand_sel_pipe #(.WIDTH(16), .N_IN(16), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_data(vec), .in_sel(in_sel),
        .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od), .out_sel(a_os),
        .out_err(a_oe), .out_valid(a_ov), .out_ready(a_or), .err_cnt(a_ec)
    );

    operand_sel_pipe #(.WIDTH(16), .N_IN(12), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_sel(in_sel),
        .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od), .out_sel(b_os),
        .out_err(b_oe), .out_valid(b_ov), .out_ready(b_or), .err_cnt(b_ec)
    );

    // scoreboard state
    logic [PW-1:0] a_q[$];
    logic [PW-1:0] b_q[$];
    int            b_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic          blk = 1'b1;
    bit            rnd_bp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: pick input sel of n, zero data and flag err when out of range
    function automatic logic [PW-1:0] model(input logic [255:0] v, input int sel, input int n);
        if (sel < n) return {v[sel*16 +: 16], 4'(sel), 1'b0};
        return {16'h0000, 4'(sel), 1'b1};
    endfunction

    // in_ready may only rise one edge after reset is released
    always @(posedge clk) blk <= rst;

    // reset discards everything held and the error count
    always @(posedge clk) begin
        if (rst) begin
            a_q.delete();
            b_q.delete();
            b_cnt = 0;
        end
    end

    // random downstream backpressure for instance a
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) a_or = 1'($urandom_range(0, 1));
        end
    end

    // driver: present one request and hold it until accepted
    task automatic send(input int which, input int sel);
        bit done = 1'b0;
        a_iv   = 1'b0;
        b_iv   = 1'b0;
        in_sel = 4'(sel);
        if (which == 0) a_iv = 1'b1; else b_iv = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk);
            if (which == 0 && a_ir) begin
                done = 1'b1;
                a_q.push_back(model(vec, sel, 16));
            end else if (which == 1 && b_ir) begin
                done = 1'b1;
                b_q.push_back(model(vec, sel, 12));
                if (sel >= 12 && b_cnt < 3) b_cnt++;
            end
        end
        chk("accept_timeout", 32'(done), 32'd1);
        #1;
    endtask

    task automatic rand_vec();
        for (int k = 0; k < 8; k++) vec[k*32 +: 32] = $urandom;
    endtask

    task automatic idle(input int n);
        a_iv = 1'b0;
        b_iv = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_sel = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
    endtask

    // monitor a: queue front must be what is presented; pop on delivery
    always @(negedge clk) begin
        chk("a_valid", 32'(a_ov), 32'(a_q.size() != 0));
        chk("a_ready", 32'(a_ir), 32'(!blk && a_q.size() < 2));
        chk("a_errcnt", 32'(a_ec), 32'd0);
        if (a_ov && a_q.size() != 0) begin
            chk("a_result", 32'({a_od, a_os, a_oe}), 32'(a_q[0]));
            if (a_or) void'(a_q.pop_front());
        end
    end

    // monitor b
    always @(negedge clk) begin
        chk("b_valid", 32'(b_ov), 32'(b_q.size() != 0));
        chk("b_ready", 32'(b_ir), 32'(!blk && b_q.size() < 2));
        chk("b_errcnt", 32'(b_ec), 32'(b_cnt));
        if (b_ov && b_q.size() != 0) begin
            chk("b_result", 32'({b_od, b_os, b_oe}), 32'(b_q[0]));
            if (b_or) void'(b_q.pop_front());
        end
    end

    initial begin
        a_iv = 1'b0;
        b_iv = 1'b0;
        a_or = 1'b1;
        in_sel = 4'd0;
        for (int k = 0; k < 16; k++) vec[k*16 +: 16] = 16'h1000 + 16'(k);

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_data", 32'(a_od), 32'd0);
        chk("rst_out_sel", 32'(a_os), 32'd0);
        chk("rst_out_err", 32'(a_oe), 32'd0);
        chk("rst_out_valid", 32'(a_ov), 32'd0);
        chk("rst_in_ready", 32'(a_ir), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // first item after reset release
        send(0, 5);
        @(negedge clk);
        chk("first_valid", 32'(a_ov), 32'd1);
        chk("first_data", 32'(a_od), 32'h1005);
        chk("first_sel", 32'(a_os), 32'd5);
        chk("first_err", 32'(a_oe), 32'd0);
        idle(2);

        // back-to-back streaming
        for (int s = 0; s < 16; s++) send(0, s);
        idle(3);

        // backpressure into FULL, then drain
        a_or = 1'b0;
        send(0, 3);
        send(0, 7);
        idle(3);
        chk("bp_ready_low", 32'(a_ir), 32'd0);
        chk("bp_hold_data", 32'(a_od), 32'h1003);
        a_or = 1'b1;
        idle(4);

        // out-of-range selects on N_IN=12, counter saturation at 3
        send(1, 13);
        @(negedge clk);
        chk("oor_data", 32'(b_od), 32'd0);
        chk("oor_err", 32'(b_oe), 32'd1);
        chk("oor_cnt1", 32'(b_ec), 32'd1);
        for (int i = 0; i < 4; i++) send(1, 13);
        send(1, 2);
        send(1, 11);
        send(1, 12);
        idle(2);
        chk("oor_cnt_sat", 32'(b_ec), 32'd3);

        // reset while FULL
        a_or = 1'b0;
        send(0, 3);
        send(0, 7);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rf_valid", 32'(a_ov), 32'd0);
        chk("rf_errcnt_b", 32'(b_ec), 32'd0);
        chk("rf_ready_low", 32'(a_ir), 32'd0);
        @(negedge clk);
        chk("rf_ready_high", 32'(a_ir), 32'd1);
        a_or = 1'b1;
        idle(2);

        // randomized traffic with backpressure and changing inputs
        rnd_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rand_vec();
            if ($urandom_range(0, 3) == 0) idle(1);
            else send($urandom_range(0, 1), $urandom_range(0, 15));
        end

        // drain
        rnd_bp = 1'b0;
        a_or = 1'b1;
        idle(1);
        for (int c = 0; c < 50 && (a_q.size() != 0 || b_q.size() != 0); c++) idle(1);
        chk("drain_a", 32'(a_q.size()), 32'd0);
        chk("drain_b", 32'(b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
